// File: rtl/data_memory.sv
// data_memory: byte-addressed slow data memory answering the CPU READ/WRITE/BUSYWAIT
// handshake. Each access stalls the CPU for LATENCY+1 cycles. The request cycle
// stalls combinationally, and then LATENCY cycles are spent in ACCESS. A single
// DONE cycle follows, in which READDATA is valid and BUSYWAIT is low.
//
// Handshake: the CPU raises exactly one of READ/WRITE and holds it until it sees
// BUSYWAIT fall. ADDRESS/WRITEDATA are captured on the edge that accepts the
// request, and later input changes are ignored until the access finishes. DONE
// always returns to IDLE, so a request still held high in DONE cannot retrigger.
module data_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 5
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] WRITEDATA,
  output logic [DATA_WIDTH-1:0] READDATA,
  output logic                  BUSYWAIT,
  output logic [1:0]            state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } fsm_t;

  fsm_t                  fsm;
  logic [3:0]            counter;
  logic                  op_write;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  req_valid;

  // Exactly one request line high; both high is treated as no request.
  assign req_valid = READ ^ WRITE;

  // Stall immediately on a valid request in IDLE and for the whole ACCESS phase.
  // Reset forces BUSYWAIT low, even when the CPU still holds a request line high.
  assign BUSYWAIT = RESET_N & (((fsm == IDLE) & req_valid) | (fsm == ACCESS));

  assign state = fsm;

  // FSM, request latching, memory array and registered read data.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm      <= IDLE;
      counter  <= '0;
      op_write <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      READDATA <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (fsm)
        IDLE: begin
          if (req_valid) begin
            op_write <= WRITE;
            addr_q   <= ADDRESS;
            data_q   <= WRITEDATA;
            counter  <= 4'd1;
            fsm      <= ACCESS;
          end
        end
        ACCESS: begin
          if (counter == LAT) begin
            if (op_write) begin
              mem[addr_q] <= data_q;
            end else begin
              READDATA <= mem[addr_q];
            end
            fsm <= DONE;
          end else begin
            counter <= counter + 4'd1;
          end
        end
        DONE: begin
          counter <= '0;
          fsm     <= IDLE;
        end
        default: begin
          counter <= '0;
          fsm     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: instance 0 uses LATENCY=5 and instance 1 uses
// LATENCY=1. Both instances share the clock and the reset.
module tb_data_memory;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic       clk;
  logic       rst_n;
  logic       rd    [2];
  logic       wr    [2];
  logic [7:0] addr  [2];
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];
  logic       busy  [2];
  logic [1:0] st    [2];

  int assertions;
  int failures;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(5)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .READ(rd[0]), .WRITE(wr[0]),
    .ADDRESS(addr[0]), .WRITEDATA(wdata[0]), .READDATA(rdata[0]),
    .BUSYWAIT(busy[0]), .state(st[0])
  );

  data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(1)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .READ(rd[1]), .WRITE(wr[1]),
    .ADDRESS(addr[1]), .WRITEDATA(wdata[1]), .READDATA(rdata[1]),
    .BUSYWAIT(busy[1]), .state(st[1])
  );

  // ---------------- driver tasks ----------------
  // One complete CPU access on instance d. The request is raised at a negedge,
  // the stall is counted at each following negedge, and the request is dropped
  // in DONE. If perturb is set, ADDRESS/WRITEDATA change during ACCESS.
  task automatic access(input int d, input bit is_wr, input logic [7:0] a,
                        input logic [7:0] wd, input int exp_cycles,
                        input bit chk_rd, input logic [7:0] exp_rd,
                        input bit perturb, input string name);
    int cycles;
    logic [7:0] prev_rd;
    @(negedge clk);
    rd[d]    = !is_wr;
    wr[d]    = is_wr;
    addr[d]  = a;
    wdata[d] = wd;
    prev_rd  = rdata[d];
    #1;
    assertions++;
    if (busy[d] !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy_same_cycle: got %b expected 1", name, busy[d]);
    end
    cycles = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy[d] !== 1'b1) break;
      cycles++;
      if (perturb && i == 0) begin
        addr[d]  = a + 8'd1;
        wdata[d] = 8'h22;
      end
      if (is_wr) begin
        assertions++;
        if (rdata[d] !== prev_rd) begin
          failures++;
          $display("FAIL %s_readdata_held: got %h expected %h", name, rdata[d], prev_rd);
        end
      end
    end
    assertions++;
    if (cycles != exp_cycles) begin
      failures++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", name, cycles, exp_cycles);
    end
    assertions++;
    if (st[d] !== S_DONE || busy[d] !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_state: got state %0d busy %b expected state 2 busy 0",
               name, st[d], busy[d]);
    end
    if (chk_rd) begin
      assertions++;
      if (rdata[d] !== exp_rd) begin
        failures++;
        $display("FAIL %s_readdata: got %h expected %h", name, rdata[d], exp_rd);
      end
    end
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      assertions++;
      if (busy[d] !== 1'b0 || rdata[d] !== 8'h00 || st[d] !== S_IDLE) begin
        failures++;
        $display("FAIL reset_state%0d: got busy %b rdata %h state %0d expected 0 00 0",
                 d, busy[d], rdata[d], st[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_read();
    access(0, 1'b0, 8'h10, 8'h00, 6, 1'b1, 8'h00, 1'b0, "first_read");
  endtask

  task automatic test_write_then_read();
    access(0, 1'b1, 8'h2A, 8'hC3, 6, 1'b0, 8'h00, 1'b0, "wr_2a");
    access(0, 1'b0, 8'h2A, 8'h00, 6, 1'b1, 8'hC3, 1'b0, "rd_2a");
  endtask

  task automatic test_inputs_ignored();
    access(0, 1'b1, 8'h05, 8'h11, 6, 1'b0, 8'h00, 1'b1, "wr_05_perturb");
    access(0, 1'b0, 8'h05, 8'h00, 6, 1'b1, 8'h11, 1'b0, "rd_05");
    access(0, 1'b0, 8'h06, 8'h00, 6, 1'b1, 8'h00, 1'b0, "rd_06");
  endtask

  task automatic test_illegal_both();
    @(negedge clk);
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h2A; wdata[0] = 8'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      assertions++;
      if (busy[0] !== 1'b0 || st[0] !== S_IDLE) begin
        failures++;
        $display("FAIL illegal_both_c%0d: got busy %b state %0d expected 0 0", i, busy[0], st[0]);
      end
      @(negedge clk);
    end
    rd[0] = 1'b0; wr[0] = 1'b0;
    access(0, 1'b0, 8'h2A, 8'h00, 6, 1'b1, 8'hC3, 1'b0, "illegal_readback");
  endtask

  task automatic test_reset_mid_access();
    access(0, 1'b1, 8'h80, 8'hFF, 6, 1'b0, 8'h00, 1'b0, "wr_80_ff");
    access(0, 1'b0, 8'h80, 8'h00, 6, 1'b1, 8'hFF, 1'b0, "rd_80_ff");
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 8'h80; wdata[0] = 8'h55;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    assertions++;
    if (busy[0] !== 1'b0 || rdata[0] !== 8'h00 || st[0] !== S_IDLE) begin
      failures++;
      $display("FAIL reset_abort: got busy %b rdata %h state %0d expected 0 00 0",
               busy[0], rdata[0], st[0]);
    end
    wr[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1'b0, 8'h80, 8'h00, 6, 1'b1, 8'h00, 1'b0, "rd_80_after_reset");
  endtask

  task automatic test_latency_one();
    access(1, 1'b1, 8'hFF, 8'h7E, 2, 1'b0, 8'h00, 1'b0, "lat1_wr");
    access(1, 1'b0, 8'hFF, 8'h00, 2, 1'b1, 8'h7E, 1'b0, "lat1_rd");
  endtask

  task automatic test_back_to_back();
    access(0, 1'b1, 8'h33, 8'hA5, 6, 1'b0, 8'h00, 1'b0, "b2b_wr");
    access(0, 1'b0, 8'h33, 8'h00, 6, 1'b1, 8'hA5, 1'b0, "b2b_rd");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    assertions = 0;
    failures   = 0;
    test_reset();
    test_first_read();
    test_write_then_read();
    test_inputs_ignored();
    test_illegal_both();
    test_back_to_back();
    test_reset_mid_access();
    test_latency_one();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressed data memory. It is the responder end of the CPU's READ/WRITE/BUSYWAIT handshake used by lwd/lwi/swd/swi.
- Sits on the CPU data-memory port. ADDRESS comes from the ALU result, WRITEDATA from the register file, and READDATA feeds the writeback mux.
- Models a slow memory: every access stalls the CPU for a fixed number of cycles by holding BUSYWAIT high.

Parameters:
- ADDR_WIDTH, 8, address bits; depth = 2^ADDR_WIDTH bytes.
- DATA_WIDTH, 8, word width.
- LATENCY, 5, cycles spent in ACCESS per request; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- READ  input  1  read request; held high by the CPU until BUSYWAIT falls.
- WRITE  input  1  write request; held high by the CPU until BUSYWAIT falls.
- ADDRESS  input  ADDR_WIDTH  byte address; sampled at request acceptance.
- WRITEDATA  input  DATA_WIDTH  store data; sampled at request acceptance.
- READDATA  output  DATA_WIDTH  load result; registered.
- BUSYWAIT  output  1  stall to the CPU.

Behaviour:
- Reset (RESET_N low, asynchronous, takes effect immediately):
  - state = IDLE, counter = 0, READDATA = 0.
  - All memory bytes cleared to 0.
  - BUSYWAIT = 0.
  - Reset asserted mid-access aborts the access: no write is committed and READDATA is 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - A request is valid when exactly one of READ and WRITE is high.
  - On a valid request, BUSYWAIT goes high combinationally in the same cycle, so the CPU stalls immediately.
  - At the next rising edge: latch op, ADDRESS and WRITEDATA; counter = 1; go to ACCESS.
- ACCESS:
  - BUSYWAIT = 1.
  - The counter increments each edge.
  - At the edge where counter == LATENCY:
    - read: READDATA <= mem[latched address].
    - write: mem[latched address] <= latched data; READDATA unchanged.
    - Go to DONE.
  - Requests and input changes during ACCESS are ignored; latched values are used.
- DONE:
  - Lasts exactly one cycle. BUSYWAIT = 0 and READDATA is valid.
  - Always returns to IDLE at the next edge, ignoring READ/WRITE. This prevents re-triggering while the CPU is dropping its request.
- Timing:
  - BUSYWAIT is high for LATENCY+1 cycles per access: the request cycle plus LATENCY ACCESS cycles.
  - A back-to-back request is accepted at the earliest in the cycle after DONE.
- READ and WRITE both high in IDLE: illegal. Treated as no request; BUSYWAIT stays 0 and memory is unchanged.
- BUSYWAIT output equation: (IDLE and READ xor WRITE) or ACCESS.
- READDATA holds its value from the last completed read until the next read completes or reset.
- The address is used modulo depth. No wrap logic is needed because ADDRESS is exactly ADDR_WIDTH bits.
- Synchronous-read semantics: READDATA never changes outside the final ACCESS edge or reset.

Test Plan:
1. Reset, then READ=1, ADDRESS=0x10 -> BUSYWAIT high in the same cycle, high for 6 cycles total; in DONE, READDATA=0x00 and BUSYWAIT=0.
2. WRITE=1, ADDRESS=0x2A, WRITEDATA=0xC3 (CPU drops WRITE when BUSYWAIT falls), then READ=1, ADDRESS=0x2A -> READDATA=0xC3 after the second stall; READDATA is not modified during the write.
3. During the ACCESS of a write to 0x05 with data 0x11, change ADDRESS to 0x06 and WRITEDATA to 0x22 -> mem[0x05]=0x11 and mem[0x06] unchanged (read back 0x00).
4. READ=1 and WRITE=1 together in IDLE for 3 cycles -> BUSYWAIT stays 0 and state stays IDLE; a subsequent read of the target address returns its old value.
5. Write 0xFF to 0x80, then pull RESET_N low on the 3rd ACCESS cycle of a write of 0x55 to 0x80 -> BUSYWAIT=0 and READDATA=0 immediately; after reset release, read of 0x80 returns 0x00.
6. With LATENCY=1: read of 0xFF after writing 0x7E -> BUSYWAIT high for exactly 2 cycles and READDATA=0x7E.
